aes_round_scheduler: RTL and testbench



---
 rtl/aes_sched_pkg.sv | 31 +++
 rtl/aes_round_scheduler_if.sv | 21 ++
 rtl/aes_rr_arbiter.sv | 34 +++
 rtl/aes_round_scheduler.sv | 141 ++++++++++++++
 tb/tb_aes_round_scheduler.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types, key-size encodings and round-count helper for the AES round scheduler.
package aes_sched_pkg;

    localparam int NUM_REQ = 2;
    localparam int RIDX_W  = 4;

    localparam logic [1:0] KEYSEL_128  = 2'b00;
    localparam logic [1:0] KEYSEL_192  = 2'b01;
    localparam logic [1:0] KEYSEL_256  = 2'b10;
    localparam logic [1:0] KEYSEL_RSVD = 2'b11;

    localparam logic [RIDX_W-1:0] NR_128 = 4'd10;
    localparam logic [RIDX_W-1:0] NR_192 = 4'd12;
    localparam logic [RIDX_W-1:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_RESP
    } sched_state_t;

    function automatic logic [RIDX_W-1:0] nr_of(input logic [1:0] keysel);
        case (keysel)
            KEYSEL_192: return NR_192;
            KEYSEL_256: return NR_256;
            default:    return NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_scheduler_if.sv
// Host-facing request/response handshake bundle of the AES round scheduler.
interface aes_round_scheduler_if;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] req_decrypt;
    logic [3:0] req_keysel;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic       rsp_err;

    modport master (
        output req_valid, req_decrypt, req_keysel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_decrypt, req_keysel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_err
    );
endinterface

// File: rtl/aes_rr_arbiter.sv
// Two-way round-robin arbiter: combinational grant, pointer flips away from the winner on accept.
module aes_rr_arbiter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    input  logic       enable,
    output logic [1:0] ready,
    output logic       grant,
    output logic       accept
);

    logic prio;

    always_comb begin
        grant = prio;
        if (!req_valid[prio]) begin
            grant = ~prio;
        end
        ready = 2'b00;
        if (enable) begin
            ready[grant] = req_valid[grant];
        end
        accept = |ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= ~grant;
        end
    end

endmodule

// File: rtl/aes_round_scheduler.sv
// Shares one iterative AES round datapath between two requesters.
// Optional AES_SCHED_PERF_EN adds saturating perf_jobs / perf_stall counters.
//   state    | meaning
//   ST_IDLE  | arbitrate, register job on accept
//   ST_LOAD  | capture block, initial AddRoundKey
//   ST_ROUND | Nr round steps, dp_last on the final one
//   ST_RESP  | hold response until rsp_ready
module aes_round_scheduler
    import aes_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    aes_round_scheduler_if.slave bus,
    output logic              dp_load,
    output logic              dp_rnd_en,
    output logic [RIDX_W-1:0] dp_rnd_idx,
    output logic              dp_first,
    output logic              dp_last,
    output logic              dp_decrypt,
    output logic [1:0]        dp_keysel,
    output logic              grant_id
`ifdef AES_SCHED_PERF_EN
    ,
    output logic [15:0]       perf_jobs,
    output logic [15:0]       perf_stall
`endif
);

    sched_state_t      state;
    logic              rsp_valid;
    logic              rsp_err;
    logic [1:0]        arb_ready;
    logic              grant;
    logic              accept;
    logic              acc_dec;
    logic [1:0]        acc_ks;
    logic [RIDX_W-1:0] idx_next;
    logic [RIDX_W-1:0] idx_end;

    aes_rr_arbiter u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (bus.req_valid),
        .enable    (state == ST_IDLE),
        .ready     (arb_ready),
        .grant     (grant),
        .accept    (accept)
    );

    assign acc_dec  = bus.req_decrypt[grant];
    assign acc_ks   = bus.req_keysel[{grant, 1'b0} +: 2];
    assign idx_next = dp_decrypt ? dp_rnd_idx - 1'b1 : dp_rnd_idx + 1'b1;
    assign idx_end  = dp_decrypt ? '0 : nr_of(dp_keysel);

    assign bus.req_ready = arb_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = grant_id;
    assign bus.rsp_err   = rsp_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            dp_load    <= 1'b0;
            dp_rnd_en  <= 1'b0;
            dp_rnd_idx <= '0;
            dp_first   <= 1'b0;
            dp_last    <= 1'b0;
            dp_decrypt <= 1'b0;
            dp_keysel  <= 2'b00;
            grant_id   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        grant_id   <= grant;
                        dp_decrypt <= acc_dec;
                        dp_keysel  <= acc_ks;
                        // Reserved key size never touches the datapath
                        if (acc_ks == KEYSEL_RSVD) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state      <= ST_LOAD;
                            dp_load    <= 1'b1;
                            dp_rnd_en  <= 1'b1;
                            dp_first   <= 1'b1;
                            dp_rnd_idx <= acc_dec ? nr_of(acc_ks) : '0;
                        end
                    end
                end
                ST_LOAD: begin
                    state      <= ST_ROUND;
                    dp_load    <= 1'b0;
                    dp_first   <= 1'b0;
                    dp_rnd_idx <= idx_next;
                    dp_last    <= (idx_next == idx_end);
                end
                ST_ROUND: begin
                    if (dp_last) begin
                        state      <= ST_RESP;
                        dp_rnd_en  <= 1'b0;
                        dp_last    <= 1'b0;
                        dp_rnd_idx <= '0;
                        rsp_valid  <= 1'b1;
                    end else begin
                        dp_rnd_idx <= idx_next;
                        dp_last    <= (idx_next == idx_end);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AES_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_jobs  <= '0;
            perf_stall <= '0;
        end else if (state == ST_RESP) begin
            if (bus.rsp_ready && perf_jobs != 16'hFFFF) begin
                perf_jobs <= perf_jobs + 1'b1;
            end
            if (!bus.rsp_ready && perf_stall != 16'hFFFF) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Scoreboard bench for aes_round_scheduler: expected responses queued at accept, checked at handshake.
module tb_aes_round_scheduler;

    typedef struct packed {
        logic id;
        logic err;
    } rsp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       dp_load;
    logic       dp_rnd_en;
    logic [3:0] dp_rnd_idx;
    logic       dp_first;
    logic       dp_last;
    logic       dp_decrypt;
    logic [1:0] dp_keysel;
    logic       grant_id;
`ifdef AES_SCHED_PERF_EN
    logic [15:0] perf_jobs;
    logic [15:0] perf_stall;
`endif

    int   vec_cnt = 0;
    int   err_cnt = 0;
    logic prio_m  = 1'b0;
    rsp_t sb_q[$];

    always #5 clk = ~clk;

    aes_round_scheduler_if bus ();

    aes_round_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .dp_load    (dp_load),
        .dp_rnd_en  (dp_rnd_en),
        .dp_rnd_idx (dp_rnd_idx),
        .dp_first   (dp_first),
        .dp_last    (dp_last),
        .dp_decrypt (dp_decrypt),
        .dp_keysel  (dp_keysel),
        .grant_id   (grant_id)
`ifdef AES_SCHED_PERF_EN
        ,
        .perf_jobs  (perf_jobs),
        .perf_stall (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every rsp handshake
    always @(negedge clk) begin
        rsp_t e;
        #1;
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_id", bus.rsp_id, e.id);
                chk("rsp_err", bus.rsp_err, e.err);
            end
        end
    end

    // Called right after a negedge; drives one job and follows it through to completion.
    task automatic run_job(input logic [1:0] v, input logic [1:0] dec, input logic [3:0] ks,
                           input int stall);
        logic       g;
        logic       e_dec;
        logic [1:0] e_ks;
        logic       e_err;
        int         nr;
        int         n;
        rsp_t       ent;
        bus.req_valid   = v;
        bus.req_decrypt = dec;
        bus.req_keysel  = ks;
        bus.rsp_ready   = (stall == 0);
        n = 0;
        #1;
        while ((bus.req_valid & bus.req_ready) == 2'b00 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40) begin
            chk("accept_timeout", n, 0);
            bus.req_valid = 2'b00;
            return;
        end
        g     = v[prio_m] ? prio_m : ~prio_m;
        chk("req_ready", bus.req_ready, g ? 2'b10 : 2'b01);
        e_dec = dec[g];
        e_ks  = g ? ks[3:2] : ks[1:0];
        e_err = (e_ks == 2'b11);
        nr    = (e_ks == 2'b00) ? 10 : (e_ks == 2'b01) ? 12 : 14;
        ent.id  = g;
        ent.err = e_err;
        sb_q.push_back(ent);
        prio_m = ~g;

        @(negedge clk);
        if (e_err) begin
            chk("err_no_dp", {dp_load, dp_rnd_en, dp_first}, 3'b000);
            chk("err_rsp_t1", bus.rsp_valid, 1);
        end else begin
            chk("load_strobes", {dp_load, dp_first, dp_rnd_en, dp_last}, 4'b1110);
            chk("load_idx", dp_rnd_idx, e_dec ? nr : 0);
            chk("load_job", {grant_id, dp_decrypt, dp_keysel}, {g, e_dec, e_ks});
            for (int k = 1; k <= nr; k++) begin
                @(negedge clk);
                chk("rnd_idx", dp_rnd_idx, e_dec ? nr - k : k);
                chk("rnd_strobes", {dp_load, dp_first, dp_rnd_en, dp_last, bus.req_ready, bus.rsp_valid},
                    {1'b0, 1'b0, 1'b1, (k == nr), 2'b00, 1'b0});
            end
            @(negedge clk);
            chk("rsp_latency", {bus.rsp_valid, dp_rnd_en}, 2'b10);
            chk("rsp_job", {grant_id, dp_decrypt, dp_keysel}, {g, e_dec, e_ks});
        end
        for (int s = 0; s < stall; s++) begin
            chk("stall_hold", {bus.rsp_valid, bus.rsp_id, bus.req_ready}, {1'b1, g, 2'b00});
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_done", bus.rsp_valid, 0);
        bus.req_valid = 2'b00;
    endtask

    initial begin
        int   n;
        logic rsp_seen;
        reset_n         = 1'b0;
        bus.req_valid   = 2'b00;
        bus.req_decrypt = 2'b00;
        bus.req_keysel  = 4'b0000;
        bus.rsp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {dp_load, dp_rnd_en, dp_rnd_idx, dp_first, dp_last, dp_decrypt, dp_keysel,
                              grant_id, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.req_ready}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_job(2'b01, 2'b00, 4'b0000, 0);      // req0 encrypt AES-128
        run_job(2'b10, 2'b10, 4'b1000, 0);      // req1 decrypt AES-256
        repeat (4) run_job(2'b11, 2'b01, 4'b0101, 0);  // both valid, AES-192, alternating
        run_job(2'b01, 2'b00, 4'b0011, 0);      // reserved key size
        run_job(2'b10, 2'b00, 4'b0000, 5);      // response back-pressure
`ifdef AES_SCHED_PERF_EN
        chk("perf_stall", perf_stall, 5);
        chk("perf_jobs", perf_jobs, 8);
`endif

        // Reset in the middle of a job
        bus.req_valid   = 2'b01;
        bus.req_decrypt = 2'b00;
        bus.req_keysel  = 4'b0000;
        bus.rsp_ready   = 1'b1;
        #1;
        chk("rst_job_ready", bus.req_ready, 2'b01);
        n = 0;
        @(negedge clk);
        while (!(dp_rnd_en && !dp_first && dp_rnd_idx == 4'd6) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_idx6", dp_rnd_idx, 6);
        bus.req_valid = 2'b00;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_async", {dp_load, dp_rnd_en, dp_rnd_idx, dp_first, dp_last, dp_decrypt, dp_keysel,
                          grant_id, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.req_ready}, 0);
`ifdef AES_SCHED_PERF_EN
        chk("rst_perf", {perf_jobs, perf_stall}, 0);
`endif
        @(negedge clk);
        reset_n  = 1'b1;
        prio_m   = 1'b0;
        rsp_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rsp_seen = rsp_seen | bus.rsp_valid;
        end
        chk("rst_no_rsp", rsp_seen, 0);
        run_job(2'b11, 2'b00, 4'b0000, 0);      // pointer back to requester 0
`ifdef AES_SCHED_PERF_EN
        chk("perf_jobs_after_rst", perf_jobs, 1);
`endif

        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, vectors %0d", vec_cnt);
        $fatal(1);
    end

endmodule
